// File: rtl/mem_stage.sv
// uRISC memory stage: takes the ixmem packet, runs the data-memory req/ack access,
// and emits a one-cycle memwb writeback pulse (with a timeout on silent memory).
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_ixmem_p1,
  input  logic        ldst_valid_ixmem_p1,
  input  logic [1:0]  store_valid_ixmem_p1,
  input  logic [15:0] mem_addr_ixmem_p1,
  input  logic [15:0] mem_data_in_ixmem_p1,
  input  logic [15:0] dest_reg_value_ixmem_p1,
  input  logic [2:0]  dest_reg_index_ixmem_p1,
  input  logic        dest_reg_write_valid_ixmem_p1,
  output logic        stall_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_err,
  output logic        valid_memwb_p1,
  output logic [15:0] dest_reg_value_memwb_p1,
  output logic [2:0]  dest_reg_index_memwb_p1,
  output logic        dest_reg_write_valid_memwb_p1,
  output logic        excep_memwb_p1
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;

  // Hold register for the access in flight
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_we;
  logic        r_stu;
  logic [2:0]  r_hold_idx;
  logic [15:0] r_hold_val;

  logic        r_wb_valid;
  logic [15:0] r_wb_val;
  logic [2:0]  r_wb_idx;
  logic        r_wb_wv;
  logic        r_wb_excep;

  logic w_idle;
  logic w_in_wait;
  logic w_accept;
  logic w_alu;
  logic w_misaligned;
  logic w_issue;
  logic w_ack;
  logic w_timeout;
  logic w_ack_wv;
  logic [15:0] w_ack_val;

  assign w_idle       = (r_state == S_IDLE);
  assign w_in_wait    = (r_state == S_WAIT);
  assign w_accept     = w_idle && valid_ixmem_p1;
  assign w_alu        = w_accept && !ldst_valid_ixmem_p1;
  assign w_misaligned = w_accept && ldst_valid_ixmem_p1 && mem_addr_ixmem_p1[0];
  assign w_issue      = w_accept && ldst_valid_ixmem_p1 && !mem_addr_ixmem_p1[0];
  assign w_ack        = w_in_wait && dmem_ack;
  // An ack arriving in the last allowed cycle still completes the access
  assign w_timeout    = w_in_wait && !dmem_ack && (r_cnt == CNT_LAST);

  // Loads and STU write a register; plain stores do not; bus errors suppress the write
  assign w_ack_wv  = !dmem_err && (!r_we || r_stu);
  assign w_ack_val = r_we ? r_hold_val : dmem_rdata;

  assign stall_mem  = w_in_wait;
  assign dmem_req   = w_in_wait;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;

  assign valid_memwb_p1                = r_wb_valid;
  assign dest_reg_value_memwb_p1       = r_wb_val;
  assign dest_reg_index_memwb_p1       = r_wb_idx;
  assign dest_reg_write_valid_memwb_p1 = r_wb_wv;
  assign excep_memwb_p1                = r_wb_excep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_stu      <= 1'b0;
      r_hold_idx <= '0;
      r_hold_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_state    <= S_WAIT;
            r_cnt      <= '0;
            r_addr     <= {mem_addr_ixmem_p1[15:1], 1'b0};
            r_wdata    <= mem_data_in_ixmem_p1;
            r_we       <= (store_valid_ixmem_p1 != 2'b00);
            r_stu      <= (store_valid_ixmem_p1 == 2'b10);
            r_hold_idx <= dest_reg_index_ixmem_p1;
            r_hold_val <= dest_reg_value_ixmem_p1;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_ack || w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writeback fields hold their value; only the valid pulse self-clears
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_val   <= '0;
      r_wb_idx   <= '0;
      r_wb_wv    <= 1'b0;
      r_wb_excep <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_alu) begin
        r_wb_valid <= 1'b1;
        r_wb_val   <= dest_reg_value_ixmem_p1;
        r_wb_idx   <= dest_reg_index_ixmem_p1;
        r_wb_wv    <= dest_reg_write_valid_ixmem_p1;
        r_wb_excep <= 1'b0;
      end else if (w_misaligned) begin
        r_wb_valid <= 1'b1;
        r_wb_val   <= dest_reg_value_ixmem_p1;
        r_wb_idx   <= dest_reg_index_ixmem_p1;
        r_wb_wv    <= 1'b0;
        r_wb_excep <= 1'b1;
      end else if (w_ack) begin
        r_wb_valid <= 1'b1;
        r_wb_val   <= w_ack_val;
        r_wb_idx   <= r_hold_idx;
        r_wb_wv    <= w_ack_wv;
        r_wb_excep <= dmem_err;
      end else if (w_timeout) begin
        r_wb_valid <= 1'b1;
        r_wb_idx   <= r_hold_idx;
        r_wb_wv    <= 1'b0;
        r_wb_excep <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model derives per-cycle expectations,
// a negedge compare process checks the DUT, plus literal checks for directed cases.
module tb_mem_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_ixmem_p1 = 1'b0;
  logic        ldst_valid_ixmem_p1 = 1'b0;
  logic [1:0]  store_valid_ixmem_p1 = 2'b00;
  logic [15:0] mem_addr_ixmem_p1 = '0;
  logic [15:0] mem_data_in_ixmem_p1 = '0;
  logic [15:0] dest_reg_value_ixmem_p1 = '0;
  logic [2:0]  dest_reg_index_ixmem_p1 = '0;
  logic        dest_reg_write_valid_ixmem_p1 = 1'b0;
  logic        stall_mem, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_err = 1'b0;
  logic        valid_memwb_p1;
  logic [15:0] dest_reg_value_memwb_p1;
  logic [2:0]  dest_reg_index_memwb_p1;
  logic        dest_reg_write_valid_memwb_p1;
  logic        excep_memwb_p1;

  mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .valid_ixmem_p1(valid_ixmem_p1),
    .ldst_valid_ixmem_p1(ldst_valid_ixmem_p1),
    .store_valid_ixmem_p1(store_valid_ixmem_p1),
    .mem_addr_ixmem_p1(mem_addr_ixmem_p1),
    .mem_data_in_ixmem_p1(mem_data_in_ixmem_p1),
    .dest_reg_value_ixmem_p1(dest_reg_value_ixmem_p1),
    .dest_reg_index_ixmem_p1(dest_reg_index_ixmem_p1),
    .dest_reg_write_valid_ixmem_p1(dest_reg_write_valid_ixmem_p1),
    .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err),
    .valid_memwb_p1(valid_memwb_p1),
    .dest_reg_value_memwb_p1(dest_reg_value_memwb_p1),
    .dest_reg_index_memwb_p1(dest_reg_index_memwb_p1),
    .dest_reg_write_valid_memwb_p1(dest_reg_write_valid_memwb_p1),
    .excep_memwb_p1(excep_memwb_p1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int req_cnt = 0;
  logic chk_en = 1'b0;

  // Expectations for the current cycle
  logic        e_req = 1'b0, e_we = 1'b0;
  logic [15:0] e_addr = '0, e_wdata = '0;
  logic        e_valid = 1'b0, e_wv = 1'b0, e_excep = 1'b0, e_chk_val = 1'b0, e_chk_idx = 1'b0;
  logic [15:0] e_val = '0;
  logic [2:0]  e_idx = '0;
  // Writeback owed in the next cycle
  logic        p_valid = 1'b0, p_wv = 1'b0, p_excep = 1'b0, p_chk_val = 1'b0, p_chk_idx = 1'b0;
  logic [15:0] p_val = '0;
  logic [2:0]  p_idx = '0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (dmem_req) req_cnt++;
    if (chk_en) begin
      cmp("stall_mem", 32'(stall_mem), 32'(e_req));
      cmp("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        cmp("dmem_addr", 32'(dmem_addr), 32'(e_addr));
        cmp("dmem_we", 32'(dmem_we), 32'(e_we));
        if (e_we) cmp("dmem_wdata", 32'(dmem_wdata), 32'(e_wdata));
      end
      cmp("valid_memwb", 32'(valid_memwb_p1), 32'(e_valid));
      if (e_valid) begin
        cmp("wb_write_valid", 32'(dest_reg_write_valid_memwb_p1), 32'(e_wv));
        cmp("wb_excep", 32'(excep_memwb_p1), 32'(e_excep));
        if (e_chk_idx) cmp("wb_index", 32'(dest_reg_index_memwb_p1), 32'(e_idx));
        if (e_chk_val) cmp("wb_value", 32'(dest_reg_value_memwb_p1), 32'(e_val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cycle(input logic req);
    e_req = req;
    e_valid = p_valid; e_wv = p_wv; e_excep = p_excep;
    e_val = p_val; e_idx = p_idx; e_chk_val = p_chk_val; e_chk_idx = p_chk_idx;
    p_valid = 1'b0;
  endtask

  task automatic owe_wb(input logic wv, input logic ex, input logic [15:0] val,
                        input logic [2:0] idx, input logic cv, input logic ci);
    p_valid = 1'b1; p_wv = wv; p_excep = ex; p_val = val; p_idx = idx;
    p_chk_val = cv; p_chk_idx = ci;
  endtask

  // Idle cycle: no packet; stray ack/err must be ignored
  task automatic idle_cycle(input logic stray_ack);
    valid_ixmem_p1 = 1'b0;
    ldst_valid_ixmem_p1 = 1'($urandom);
    mem_addr_ixmem_p1 = 16'($urandom);
    dest_reg_value_ixmem_p1 = 16'($urandom);
    dmem_ack = stray_ack;
    dmem_err = 1'($urandom);
    dmem_rdata = 16'($urandom);
    set_cycle(1'b0);
    tick();
  endtask

  // One instruction; returns the number of cycles dmem_req was seen high
  task automatic run_txn(input int id, input logic ldst, input logic [1:0] sv,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] val, input logic [2:0] idx, input logic wr,
                         input int ack_dly, input logic [15:0] rdata, input logic err,
                         output int n_req);
    int start;
    logic done;
    logic is_load, is_stu;
    is_load = (sv == 2'b00);
    is_stu  = (sv == 2'b10);
    valid_ixmem_p1 = 1'b1;
    ldst_valid_ixmem_p1 = ldst;
    store_valid_ixmem_p1 = sv;
    mem_addr_ixmem_p1 = addr;
    mem_data_in_ixmem_p1 = wdata;
    dest_reg_value_ixmem_p1 = val;
    dest_reg_index_ixmem_p1 = idx;
    dest_reg_write_valid_ixmem_p1 = wr;
    dmem_ack = 1'($urandom);
    dmem_err = 1'($urandom);
    set_cycle(1'b0);
    if (!ldst)        owe_wb(wr, 1'b0, val, idx, 1'b1, 1'b1);
    else if (addr[0]) owe_wb(1'b0, 1'b1, 16'h0, idx, 1'b0, 1'b0);
    tick();
    start = req_cnt;
    if (ldst && !addr[0]) begin
      done = 1'b0;
      for (int j = 0; j < TIMEOUT && !done; j++) begin
        dmem_ack = (j == ack_dly);
        dmem_err = (j == ack_dly) ? err : 1'($urandom);
        dmem_rdata = (j == ack_dly) ? rdata : 16'($urandom);
        e_addr = {addr[15:1], 1'b0};
        e_we = !is_load;
        e_wdata = wdata;
        set_cycle(1'b1);
        if (j == ack_dly) begin
          owe_wb(!err && (is_load || is_stu), err, is_load ? rdata : val, idx,
                 !err && (is_load || is_stu), 1'b1);
          done = 1'b1;
        end else if (j == TIMEOUT - 1) begin
          owe_wb(1'b0, 1'b1, 16'h0, idx, 1'b0, 1'b0);
        end
        tick();
      end
      dmem_ack = 1'b0;
    end
    n_req = req_cnt - start;
    $display("txn %0d: ldst=%0d type=%0d addr=%h ack_dly=%0d err=%0d req_cycles=%0d",
             id, ldst, sv, addr, ack_dly, err, n_req);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    int id;
    int kind, dly;
    logic [1:0] sv;
    logic [15:0] a;

    // Reset: all outputs low
    tick(); tick();
    cmp("reset_req", 32'(dmem_req), 32'h0);
    cmp("reset_stall", 32'(stall_mem), 32'h0);
    cmp("reset_valid", 32'(valid_memwb_p1), 32'h0);
    cmp("reset_addr", 32'(dmem_addr), 32'h0);
    cmp("reset_wb_value", 32'(dest_reg_value_memwb_p1), 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle_cycle(1'b0);

    // ALU op
    run_txn(0, 1'b0, 2'b00, 16'h0000, 16'h0, 16'h1234, 3'd3, 1'b1, 0, 16'h0, 1'b0, nr);
    cmp("alu_lit_valid", 32'(valid_memwb_p1), 32'h1);
    cmp("alu_lit_value", 32'(dest_reg_value_memwb_p1), 32'h1234);
    cmp("alu_lit_req_cycles", 32'(nr), 32'h0);
    idle_cycle(1'b0);

    // Load with 3 cycles of silence
    run_txn(1, 1'b1, 2'b00, 16'h0040, 16'h0, 16'h0, 3'd5, 1'b1, 3, 16'hBEEF, 1'b0, nr);
    cmp("load_lit_req_cycles", 32'(nr), 32'h4);
    cmp("load_lit_value", 32'(dest_reg_value_memwb_p1), 32'hBEEF);
    cmp("load_lit_wv", 32'(dest_reg_write_valid_memwb_p1), 32'h1);
    idle_cycle(1'b0);

    // STU acked in first WAIT cycle
    run_txn(2, 1'b1, 2'b10, 16'h0010, 16'h5555, 16'h0012, 3'd2, 1'b1, 0, 16'hDEAD, 1'b0, nr);
    cmp("stu_lit_req_cycles", 32'(nr), 32'h1);
    cmp("stu_lit_value", 32'(dest_reg_value_memwb_p1), 32'h0012);
    cmp("stu_lit_index", 32'(dest_reg_index_memwb_p1), 32'h2);
    idle_cycle(1'b0);

    // Misaligned ST
    run_txn(3, 1'b1, 2'b01, 16'h0011, 16'hAAAA, 16'h0, 3'd1, 1'b0, 0, 16'h0, 1'b0, nr);
    cmp("misal_lit_req_cycles", 32'(nr), 32'h0);
    cmp("misal_lit_excep", 32'(excep_memwb_p1), 32'h1);
    idle_cycle(1'b0);

    // Timeout, then late acks that must be ignored
    run_txn(4, 1'b1, 2'b00, 16'h0100, 16'h0, 16'h0, 3'd6, 1'b1, 100, 16'h0, 1'b0, nr);
    cmp("timeout_lit_req_cycles", 32'(nr), 32'd16);
    cmp("timeout_lit_excep", 32'(excep_memwb_p1), 32'h1);
    cmp("timeout_lit_wv", 32'(dest_reg_write_valid_memwb_p1), 32'h0);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Reset in the middle of a WAIT
    valid_ixmem_p1 = 1'b1; ldst_valid_ixmem_p1 = 1'b1; store_valid_ixmem_p1 = 2'b00;
    mem_addr_ixmem_p1 = 16'h0200; dmem_ack = 1'b0;
    set_cycle(1'b0);
    tick();
    e_addr = 16'h0200; e_we = 1'b0;
    set_cycle(1'b1);
    tick();
    set_cycle(1'b1);
    tick();
    chk_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    cmp("async_rst_req", 32'(dmem_req), 32'h0);
    cmp("async_rst_stall", 32'(stall_mem), 32'h0);
    cmp("async_rst_valid", 32'(valid_memwb_p1), 32'h0);
    tick();
    rst = 1'b1;
    p_valid = 1'b0;
    chk_en = 1'b1;
    idle_cycle(1'b1);
    run_txn(5, 1'b0, 2'b00, 16'h0, 16'h0, 16'h0ACE, 3'd7, 1'b1, 0, 16'h0, 1'b0, nr);
    cmp("post_rst_lit_value", 32'(dest_reg_value_memwb_p1), 32'h0ACE);

    // Randomized traffic
    id = 6;
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 99);
      sv = 2'($urandom);
      a = 16'($urandom);
      if (kind < 60) a[0] = 1'b0;
      dly = $urandom_range(0, 99);
      if (dly < 60)      dly = $urandom_range(0, 4);
      else if (dly < 75) dly = $urandom_range(5, TIMEOUT - 2);
      else if (dly < 85) dly = TIMEOUT - 1;
      else               dly = TIMEOUT + 3;
      run_txn(id, (kind >= 30), sv, a, 16'($urandom), 16'($urandom), 3'($urandom),
              1'($urandom), dly, 16'($urandom), ($urandom_range(0, 99) < 15), nr);
      id++;
      if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom));
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the uRISC 16-bit pipeline.
- Consumes the ixmem_p1 pipeline registers produced by the execute stage: result, destination register, load/store address, store data and store type.
- Performs the data-memory access over a req/ack handshake and stalls execute while an access is outstanding.
- Presents a one-cycle-valid writeback packet (memwb_p1) to the register file.

Parameters:
TIMEOUT, 16, max WAIT cycles without dmem_ack before an access is aborted with an exception (>=2)
CNT_W, 5, width of the timeout counter; must hold TIMEOUT

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
valid_ixmem_p1  input  1  ixmem packet holds a live instruction
ldst_valid_ixmem_p1  input  1  instruction is a load or store
store_valid_ixmem_p1  input  2  00 load, 01 ST, 10 STU, 11 treated as ST
mem_addr_ixmem_p1  input  16  byte address from ALU
mem_data_in_ixmem_p1  input  16  store data
dest_reg_value_ixmem_p1  input  16  ALU result (STU: updated base)
dest_reg_index_ixmem_p1  input  3  destination register
dest_reg_write_valid_ixmem_p1  input  1  instruction writes a register
stall_mem  output  1  execute must hold ixmem inputs stable
dmem_req  output  1  memory request
dmem_we  output  1  1 store, 0 load
dmem_addr  output  16  word-aligned address
dmem_wdata  output  16  store data
dmem_ack  input  1  request completed this cycle
dmem_rdata  input  16  load data, valid with ack
dmem_err  input  1  bus error, valid with ack
valid_memwb_p1  output  1  writeback packet valid (one cycle per instruction)
dest_reg_value_memwb_p1  output  16  writeback value
dest_reg_index_memwb_p1  output  3  writeback register
dest_reg_write_valid_memwb_p1  output  1  register write enable
excep_memwb_p1  output  1  misaligned, bus error or timeout

Behaviour:
- FSM states: IDLE, WAIT. On rst low: state=IDLE, counter=0, every output 0, asynchronously. Reset during WAIT drops dmem_req immediately; the access is abandoned.
- stall_mem = (state==WAIT). Combinational from state only.
- In IDLE, accept the packet when valid_ixmem_p1=1:
  - Non-memory (ldst=0): next edge loads memwb registers: value and index from ixmem, write_valid from ixmem, valid=1, excep=0. Zero stall.
  - Memory op with mem_addr[0]=1 (misaligned): no request is issued. Next edge: valid=1, excep=1, write_valid=0.
  - Aligned memory op: latch addr, wdata, we=(store_valid!=00), type, index and STU value into the hold register. Go to WAIT and clear the counter. memwb valid=0 this edge.
- In WAIT:
  - dmem_req=1. dmem_addr, dmem_we and dmem_wdata are driven from the hold register and stay stable until ack.
  - Counter increments each cycle.
  - On dmem_ack=1 the next edge goes to IDLE and sets valid_memwb=1:
    - load: value=dmem_rdata, write_valid=1
    - ST: write_valid=0
    - STU: value=held dest_reg_value, write_valid=1
    - excep=dmem_err; if dmem_err=1, write_valid is forced to 0.
  - Ack in the first WAIT cycle is legal. Minimum memory latency is 2 edges from accept to valid_memwb.
  - If the counter reaches TIMEOUT-1 without ack: go to IDLE and drop req. Writeback valid=1, excep=1, write_valid=0.
- dmem_ack and dmem_err are ignored while in IDLE (dmem_req=0).
- valid_memwb_p1 is a single-cycle pulse per instruction. All memwb outputs hold their last values when valid=0; only valid is cleared each cycle.
- During the cycle that WAIT exits, stall_mem is still 1. The held ixmem packet is accepted in the following IDLE cycle, so there is no back-to-back accept in the same edge.
- valid_ixmem_p1=0 in IDLE: valid_memwb=0, nothing else changes.

Test Plan:
- Reset then an ALU op: valid=1, ldst=0, value=16'h1234, idx=3, wr=1 -> next cycle valid_memwb=1, value 1234, idx 3, write_valid=1, stall_mem never set.
- Load addr=16'h0040, ack held low 3 cycles then rdata=16'hBEEF with ack -> dmem_req high 4 cycles with addr 0040 and we=0, stall_mem high 4 cycles; the cycle after ack: valid=1, value BEEF, write_valid=1.
- STU addr=16'h0010, wdata=16'h5555, value=16'h0012, idx=2, ack in first WAIT cycle -> one req cycle with we=1 and wdata 5555; writeback value 0012, idx 2, write_valid=1, excep=0.
- Misaligned ST addr=16'h0011 -> dmem_req stays 0, stall_mem 0; next cycle valid=1, excep=1, write_valid=0.
- Load with no ack and TIMEOUT=16 -> req high exactly 16 cycles, then valid=1, excep=1, write_valid=0. A late ack afterwards is ignored.
- Assert rst low mid-WAIT -> dmem_req, stall_mem and valid_memwb drop 0 with no clock edge. After release, a new ALU op completes normally.
